// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational integer ops plus an iterative
// multiply/divide unit that owns the architectural HI/LO registers.
// Ports: clk, rst (async, active-high); A, B operands; ALUOp op code;
//   start launches ops 11-14; C result, Zero (C == 0);
//   busy while iterating, done one-cycle pulse; HI/LO result registers.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [SW-1:0]    sh;
    logic             md_op, sgn, is_div, accept;
    logic [WIDTH-1:0] abs_a, abs_b;

    logic [WIDTH:0]     sum, rsh;
    logic [WIDTH-1:0]   rsub;
    logic               ge;
    logic [WIDTH-1:0]   acc_n, wrk_n;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    // Combinational ALU
    assign sh = A[SW-1:0];

    always_comb begin
        C = A;
        unique case (ALUOp)
            4'd0:  C = A;
            4'd1:  C = A + B;
            4'd2:  C = A - B;
            4'd3:  C = A & B;
            4'd4:  C = A | B;
            4'd5:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd6:  C = {{(WIDTH-1){1'b0}}, A < B};
            4'd7:  C = B << sh;
            4'd8:  C = ~(A | B);
            4'd9:  C = B >> sh;
            4'd10: C = $unsigned($signed(B) >>> sh);
            4'd15: C = hi_q;
            default: C = lo_q;
        endcase
    end

    assign Zero = (C == '0);

    // Operand conditioning at launch
    assign md_op  = (ALUOp >= 4'd11) && (ALUOp <= 4'd14);
    assign sgn    = (ALUOp == 4'd11) || (ALUOp == 4'd13);
    assign is_div = (ALUOp == 4'd13) || (ALUOp == 4'd14);
    assign abs_a  = (sgn && A[WIDTH-1]) ? -A : A;
    assign abs_b  = (sgn && B[WIDTH-1]) ? -B : B;
    // A pending divide-by-zero still occupies the unit for one cycle
    assign accept = MD_EN && start && md_op
                    && (state_q != CALC) && !dz_q;

    // One iteration step. Multiply: acc:wrk shift right with add of
    // the multiplicand. Divide: restoring step, quotient enters wrk LSB.
    always_comb begin
        sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
        rsh  = {acc_q, wrk_q[WIDTH-1]};
        ge   = (rsh >= {1'b0, opb_q});
        rsub = rsh[WIDTH-1:0] - opb_q;
        if (div_q) begin
            acc_n = ge ? rsub : rsh[WIDTH-1:0];
            wrk_n = {wrk_q[WIDTH-2:0], ge};
        end else begin
            acc_n = sum[WIDTH:1];
            wrk_n = {sum[0], wrk_q[WIDTH-1:1]};
        end
        prod   = {acc_n, wrk_n};
        prod_s = negq_q ? -prod : prod;
        quo_s  = negq_q ? -wrk_n : wrk_n;
        rem_s  = negr_q ? -acc_n : acc_n;
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = acc_n;
                wrk_d = wrk_n;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (div_q) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (dz_q) begin
                    dz_d    = 1'b0;
                    hi_d    = acc_q;
                    lo_d    = '1;
                    state_d = DONE;
                end else if (accept) begin
                    div_d  = is_div;
                    negq_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                    negr_d = sgn && A[WIDTH-1];
                    if (is_div && (B == '0)) begin
                        // Dividend parked in acc for HI
                        dz_d  = 1'b1;
                        acc_d = A;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        wrk_d   = abs_a;
                        opb_d   = abs_b;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: WIDTH=32 and WIDTH=8 instances.
// Ports driven on the falling edge, outputs sampled on the falling edge.
module tb_alu_muldiv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a, b, c, hi, lo;
    logic [3:0]  op;
    logic        start, zero, busy, done;

    logic [7:0]  a8, b8, c8, hi8, lo8;
    logic [3:0]  op8;
    logic        start8, zero8, busy8, done8;

    int pass_cnt = 0;
    int total = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat, bc;
    } v32_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, hi, lo;
        int         lat, bc;
    } v8_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, c;
    } vc_t;

    alu_muldiv #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .ALUOp(op),
        .start(start), .C(c), .Zero(zero), .busy(busy),
        .done(done), .HI(hi), .LO(lo)
    );

    alu_muldiv #(.WIDTH(8), .MD_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .ALUOp(op8),
        .start(start8), .C(c8), .Zero(zero8), .busy(busy8),
        .done(done8), .HI(hi8), .LO(lo8)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        a = '0; b = '0; op = '0; a8 = '0; b8 = '0; op8 = '0;
        #2;
        total++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        else pass_cnt++;
        total++;
        if ({hi, lo} !== 64'h0)
            $display("FAIL reset_hilo: got %h want 0", {hi, lo});
        else pass_cnt++;
        total++;
        if ({busy8, done8, hi8, lo8} !== 18'h0)
            $display("FAIL reset_w8: got %h want 0", {busy8, done8, hi8, lo8});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_comb();
        vc_t v[11];
        v[0]  = '{4'd0,  32'h12345678, 32'h0,        32'h12345678};
        v[1]  = '{4'd1,  32'h7fffffff, 32'h1,        32'h80000000};
        v[2]  = '{4'd2,  32'h5,        32'h5,        32'h0};
        v[3]  = '{4'd3,  32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000};
        v[4]  = '{4'd4,  32'hf0f0f0f0, 32'h0f0f0000, 32'hfffff0f0};
        v[5]  = '{4'd5,  32'hffffffff, 32'h1,        32'h1};
        v[6]  = '{4'd6,  32'hffffffff, 32'h1,        32'h0};
        v[7]  = '{4'd7,  32'h24,       32'h1,        32'h10};
        v[8]  = '{4'd8,  32'h0,        32'h0,        32'hffffffff};
        v[9]  = '{4'd9,  32'h4,        32'h80000000, 32'h08000000};
        v[10] = '{4'd10, 32'h4,        32'h80000000, 32'hf8000000};
        for (int i = 0; i < 11; i++) begin
            op = v[i].op; a = v[i].a; b = v[i].b;
            #1;
            total++;
            if (c !== v[i].c)
                $display("FAIL comb_c op%0d: got %h want %h", v[i].op, c, v[i].c);
            else pass_cnt++;
            total++;
            if (zero !== (v[i].c == 32'h0))
                $display("FAIL comb_zero op%0d: got %b want %b",
                         v[i].op, zero, v[i].c == 32'h0);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_muldiv32();
        v32_t v[6];
        int lat, bc;
        v[0] = '{4'd11, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb, 32, 32};
        v[1] = '{4'd12, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h1, 32, 32};
        v[2] = '{4'd13, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, 32, 32};
        v[3] = '{4'd14, 32'd100, 32'd7, 32'd2, 32'd14, 32, 32};
        v[4] = '{4'd13, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000, 32, 32};
        v[5] = '{4'd13, 32'd1234, 32'd0, 32'd1234, 32'hffffffff, 1, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 0; bc = 0;
            while (!done && lat < 100) begin
                if (busy) bc++;
                a = $urandom; b = $urandom;
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat !== v[i].lat)
                $display("FAIL md32_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
            else pass_cnt++;
            total++;
            if (bc !== v[i].bc)
                $display("FAIL md32_busy[%0d]: got %0d want %0d", i, bc, v[i].bc);
            else pass_cnt++;
            total++;
            if ({hi, lo} !== {v[i].hi, v[i].lo})
                $display("FAIL md32_hilo[%0d]: got %h want %h",
                         i, {hi, lo}, {v[i].hi, v[i].lo});
            else pass_cnt++;
            total++;
            if (c !== v[i].lo)
                $display("FAIL md32_c[%0d]: got %h want %h", i, c, v[i].lo);
            else pass_cnt++;
            @(negedge clk);
            total++;
            if ({busy, done} !== 2'b00)
                $display("FAIL md32_pulse[%0d]: got %b want 00", i, {busy, done});
            else pass_cnt++;
        end
        op = 4'd15;
        #1;
        total++;
        if (c !== 32'd1234)
            $display("FAIL mfhi: got %h want %h", c, 32'd1234);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 32'd3; b = 32'd5; op = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 3) begin
                a = 32'd100; b = 32'd7; op = 4'd14; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 32)
            $display("FAIL ign_lat: got %0d want 32", lat);
        else pass_cnt++;
        total++;
        if ({hi, lo} !== 64'd15)
            $display("FAIL ign_hilo: got %h want %h", {hi, lo}, 64'd15);
        else pass_cnt++;
        a = 32'd6; b = 32'd7; op = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({busy, hi, lo} !== {1'b1, 64'd15})
            $display("FAIL b2b_hold: got %h want %h", {busy, hi, lo}, {1'b1, 64'd15});
        else pass_cnt++;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 32)
            $display("FAIL b2b_lat: got %0d want 32", lat);
        else pass_cnt++;
        total++;
        if ({hi, lo} !== 64'd42)
            $display("FAIL b2b_hilo: got %h want %h", {hi, lo}, 64'd42);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        a = 32'hfffffffd; b = 32'd7; op = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1)
            $display("FAIL abort_pre_busy: got %b want 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, hi, lo} !== 66'h0)
            $display("FAIL abort_clear: got %h want 0", {busy, done, hi, lo});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0)
            $display("FAIL abort_nodone: got %0d want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_w8();
        v8_t v[6];
        int lat, bc;
        v[0] = '{4'd11, 8'hfd, 8'h07, 8'hff, 8'heb, 8, 8};
        v[1] = '{4'd12, 8'hff, 8'hff, 8'hfe, 8'h01, 8, 8};
        v[2] = '{4'd13, 8'hf9, 8'h02, 8'hff, 8'hfd, 8, 8};
        v[3] = '{4'd14, 8'd100, 8'd7, 8'd2, 8'd14, 8, 8};
        v[4] = '{4'd13, 8'h80, 8'hff, 8'h00, 8'h80, 8, 8};
        v[5] = '{4'd13, 8'h12, 8'h00, 8'h12, 8'hff, 1, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a8 = v[i].a; b8 = v[i].b; op8 = v[i].op; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = 0; bc = 0;
            while (!done8 && lat < 100) begin
                if (busy8) bc++;
                a8 = 8'($urandom); b8 = 8'($urandom);
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat !== v[i].lat)
                $display("FAIL md8_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
            else pass_cnt++;
            total++;
            if (bc !== v[i].bc)
                $display("FAIL md8_busy[%0d]: got %0d want %0d", i, bc, v[i].bc);
            else pass_cnt++;
            total++;
            if ({hi8, lo8} !== {v[i].hi, v[i].lo})
                $display("FAIL md8_hilo[%0d]: got %h want %h",
                         i, {hi8, lo8}, {v[i].hi, v[i].lo});
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_muldiv32();
        test_back_to_back();
        test_reset_abort();
        test_w8();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
